// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// state encoding, default operand width and iteration counter width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH + 1);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit:
// launch/operands, flush, mthi/mtlo writes, and HI/LO/status back.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, we_hi, we_lo, wd,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, we_hi, we_lo, wd,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply (product accumulates in place,
// multiplicand shifts left) or restoring shift-subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0]   opb_o
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Divide: acc low half is the partial remainder, opb shifts dividend bits
    // out of the top while quotient bits enter at the bottom.
    assign rem_sh = {acc_i[WIDTH-1:0], opb_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opa_i[WIDTH-1:0]};

    always_comb begin
        acc_o = acc_i;
        opa_o = opa_i;
        opb_o = opb_i;
        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                opb_o = {opb_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
                opb_o = {opb_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (opb_i[0]) begin
                acc_o = acc_i + opa_i;
            end
            opa_o = opa_i << 1;
            opb_o = opb_i >> 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; IDLE -> RUN (WIDTH steps) -> FIX.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic               is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_s, opa_s;
    logic [WIDTH-1:0]   opb_s;
    logic               op_signed, op_div, a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign a_neg     = op_signed & bus.a[WIDTH-1];
    assign b_neg     = op_signed & bus.b[WIDTH-1];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div_q),
        .acc_i (acc_q),
        .opa_i (opa_q),
        .opb_i (opb_q),
        .acc_o (acc_s),
        .opa_o (opa_s),
        .opb_o (opb_s)
    );

    // Remainder follows the dividend sign; for x/0 this restores the raw dividend.
    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -opb_q : opb_q;
    assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        zero_d   = zero_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        case (state_q)
            IDLE: begin
                if (bus.we_hi) hi_d = bus.wd;
                if (bus.we_lo) lo_d = bus.wd;
                if (bus.start && !bus.flush) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    is_div_d = op_div;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    zero_d   = op_div && (bus.b == '0);
                    acc_d    = '0;
                    if (op_div) begin
                        opa_d = {{WIDTH{1'b0}}, magnitude(bus.b, b_neg)};
                        opb_d = magnitude(bus.a, a_neg);
                    end else begin
                        opa_d = {{WIDTH{1'b0}}, magnitude(bus.a, a_neg)};
                        opb_d = magnitude(bus.b, b_neg);
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = acc_s;
                    opa_d = opa_s;
                    opb_d = opb_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                    if (!is_div_q && (opb_s == '0)) state_d = FIX;
`endif
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = zero_q ? '1 : quo_fix;
                        hi_d = rem_fix;
                        dz_d = zero_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded at launch.
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        zero_q   <= zero_d;
        acc_q    <= acc_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, flush,
// ignored start/mthi while busy, divide by zero and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M35 = 4;
    localparam int LAT_67  = 4;
`else
    localparam int LAT_M35 = 33;
    localparam int LAT_67  = 33;
`endif
    localparam int LAT_FULL = 33;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   lat;
    logic busy_after_start;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op at the next edge and count edges until done appears.
    task automatic run_op(input op_e o, input logic [31:0] av, input logic [31:0] bv,
                          output int n);
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_after_start = bus.busy;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wd    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_hi",   bus.hi, 64'h0);
        check("reset_lo",   bus.lo, 64'h0);
        check("reset_busy", bus.busy, 64'h0);
        check("reset_done", bus.done, 64'h0);
        check("reset_dbz",  bus.div_by_zero, 64'h0);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_lat",      lat, LAT_FULL);
        check("multu_busy_e0",  busy_after_start, 64'h1);
        check("multu_busy_end", bus.busy, 64'h0);
        check("multu_hi",       bus.hi, 64'hFFFF_FFFE);
        check("multu_lo",       bus.lo, 64'h0000_0001);
        check("multu_dbz",      bus.div_by_zero, 64'h0);
        tick();
        check("done_pulse",     bus.done, 64'h0);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
        check("mult_lat", lat, LAT_M35);
        check("mult_hi",  bus.hi, 64'hFFFF_FFFF);
        check("mult_lo",  bus.lo, 64'hFFFF_FFF1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", lat, LAT_FULL);
        check("div_lo",  bus.lo, 64'hFFFF_FFFD);
        check("div_hi",  bus.hi, 64'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf_lo",  bus.lo, 64'h8000_0000);
        check("div_ovf_hi",  bus.hi, 64'h0);
        check("div_ovf_dbz", bus.div_by_zero, 64'h0);

        run_op(OP_DIVU, 32'd10, 32'd0, lat);
        check("dbz_lat", lat, LAT_FULL);
        check("dbz_lo",  bus.lo, 64'hFFFF_FFFF);
        check("dbz_hi",  bus.hi, 64'h0000_000A);
        check("dbz_flag", bus.div_by_zero, 64'h1);

        // mthi / mtlo in IDLE
        bus.we_hi = 1'b1;
        bus.wd    = 32'h1234;
        tick();
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b1;
        bus.wd    = 32'h5678;
        tick();
        bus.we_lo = 1'b0;
        check("mthi", bus.hi, 64'h1234);
        check("mtlo", bus.lo, 64'h5678);

        // divu 100/7 with mthi while busy, flushed at the tenth edge
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus.we_hi = (i == 3);
            bus.wd    = 32'hDEAD_BEEF;
            tick();
        end
        bus.we_hi = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 64'h0);
        check("flush_done", bus.done, 64'h0);
        check("flush_hi",   bus.hi, 64'h1234);
        begin
            int late_done;
            late_done = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (bus.done || bus.busy) late_done++;
            end
            check("flush_no_done", late_done, 64'h0);
        end
        check("flush_lo", bus.lo, 64'h5678);

        // divu 100/7 with a multu start pulse mid-run that must be ignored
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            bus.start = (i == 5);
            bus.op    = (i == 5) ? OP_MULTU : OP_DIVU;
            bus.a     = (i == 5) ? 32'd3 : 32'd100;
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check("ign_start_lat", lat, LAT_FULL);
        check("ign_start_lo",  bus.lo, 64'd14);
        check("ign_start_hi",  bus.hi, 64'd2);
        tick();
        check("ign_start_idle", bus.busy, 64'h0);

        // asynchronous reset in the middle of RUN
        bus.op    = OP_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'hFFFF_0000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_hi",   bus.hi, 64'h0);
        check("arst_lo",   bus.lo, 64'h0);
        check("arst_busy", bus.busy, 64'h0);
        check("arst_done", bus.done, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        run_op(OP_MULTU, 32'd6, 32'd7, lat);
        check("post_rst_lat", lat, LAT_67);
        check("post_rst_lo",  bus.lo, 64'd42);
        check("post_rst_hi",  bus.hi, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
